// File: rtl/fpu_op_sequencer.sv
// Request FIFO plus a single-issue sequencer that holds FP ALU operands for a
// per-opcode settle time, then returns the captured result on a tagged response.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the head when one is present
// DRIVE | ALU inputs held; cnt counts down the remaining settle cycles
// RESP  | response presented; held stable until the consumer takes it
module fpu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ADD_LAT = 2,
  parameter int MIN_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int XOR_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_sel,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       fifo_op  [DEPTH];
  logic [31:0]      fifo_a   [DEPTH];
  logic [31:0]      fifo_b   [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       cnt;

  logic             full, empty, push, pop;
  logic [2:0]       head_op;
  logic [31:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;
  logic             head_legal;

  function automatic logic [3:0] lat_m1(input logic [2:0] op);
    case (op)
      3'd0:    lat_m1 = 4'(ADD_LAT - 1);
      3'd1:    lat_m1 = 4'(MIN_LAT - 1);
      3'd2:    lat_m1 = 4'(MUL_LAT - 1);
      3'd3:    lat_m1 = 4'(DIV_LAT - 1);
      3'd4:    lat_m1 = 4'(XOR_LAT - 1);
      default: lat_m1 = 4'd0;
    endcase
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign head_op    = fifo_op[rd_ptr];
  assign head_a     = fifo_a[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign head_tag   = fifo_tag[rd_ptr];
  assign head_legal = (head_op <= 3'd4);
  assign busy       = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_legal ? DRIVE : RESP;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Entry storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]  <= req_op;
      fifo_a[wr_ptr]   <= req_a;
      fifo_b[wr_ptr]   <= req_b;
      fifo_tag[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            rsp_tag <= head_tag;
            if (head_legal) begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_sel <= head_op;
              cnt     <= lat_m1(head_op);
            end else begin
              // Illegal opcodes bypass the ALU entirely and leave its inputs alone.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: table of single-request vectors plus
// hand-written backpressure, mid-operation reset and mixed-op throughput runs.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in ALU: integer ops, plus the two FP vectors used below.
  function automatic logic [31:0] alu_model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      3'd0:    return (a == 32'h40400000 && b == 32'h3F800000) ? 32'h40800000 : a + b;
      3'd1:    return (a < b) ? a : b;
      3'd2:    return a * b;
      3'd3:    return (a == 32'h41000000 && b == 32'h40000000) ? 32'h40800000 :
                      ((b == 0) ? 32'h0 : a / b);
      3'd4:    return a ^ b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_out = alu_model(alu_sel, alu_a, alu_b);

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] prev_a, prev_b, exp_a, exp_b;
    logic [2:0]  prev_sel, exp_sel;
    logic [31:0] held_data;
    logic [3:0]  held_tag;
    logic        got, sel_ok, stable, seen;
    int          t0, acc, n, spurious, idx;
    int          exp_rise [4];
    logic [2:0]  m_op  [4];
    logic [31:0] m_a   [4];
    logic [31:0] m_b   [4];
    logic [31:0] m_exp [4];
    int          m_lat [4];

    vecs[0] = '{3'd0, 32'h40400000, 32'h3F800000, 4'd5,  32'h40800000, 1'b0, 4};
    vecs[1] = '{3'd3, 32'h41000000, 32'h40000000, 4'd3,  32'h40800000, 1'b0, 10};
    vecs[2] = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 4'd9,  32'h00000000, 1'b1, 2};
    vecs[3] = '{3'd2, 32'd6,        32'd7,        4'd2,  32'd42,       1'b0, 5};
    vecs[4] = '{3'd1, 32'h00000100, 32'h000000FF, 4'hA,  32'h000000FF, 1'b0, 3};
    vecs[5] = '{3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 4'hF,  32'hF0F00F0F, 1'b0, 3};
    vecs[6] = '{3'd7, 32'h00000001, 32'h00000002, 4'd0,  32'h00000000, 1'b1, 2};
    vecs[7] = '{3'd5, 32'hCAFEBABE, 32'h00000003, 4'd6,  32'h00000000, 1'b1, 2};

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1;
    step(); step();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_tag",   rsp_tag, 0);
    check("rst_alu_a",     alu_a, 0);
    check("rst_alu_b",     alu_b, 0);
    check("rst_alu_sel",   alu_sel, 0);
    check("rst_busy",      busy, 0);
    rst = 1'b0;
    step();

    // Single requests from idle, rsp_ready held high.
    for (int v = 0; v < 8; v++) begin
      prev_a = alu_a; prev_b = alu_b; prev_sel = alu_sel;
      if (vecs[v].op <= 3'd4) begin
        exp_a = vecs[v].a; exp_b = vecs[v].b; exp_sel = vecs[v].op;
      end else begin
        exp_a = prev_a; exp_b = prev_b; exp_sel = prev_sel;
      end
      req_valid = 1'b1; req_op = vecs[v].op; req_a = vecs[v].a;
      req_b = vecs[v].b; req_tag = vecs[v].tag;
      t0 = cyc;
      step();
      req_valid = 1'b0;
      got = 1'b0; sel_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
        if (cyc - t0 >= 2 && alu_sel !== exp_sel) sel_ok = 1'b0;
        if (rsp_valid) begin
          got = 1'b1;
          break;
        end
        step();
      end
      check($sformatf("v%0d_seen", v), got, 1);
      check($sformatf("v%0d_lat", v), cyc - t0, vecs[v].exp_lat);
      check($sformatf("v%0d_data", v), rsp_data, vecs[v].exp_data);
      check($sformatf("v%0d_tag", v), rsp_tag, vecs[v].tag);
      check($sformatf("v%0d_err", v), rsp_err, vecs[v].exp_err);
      check($sformatf("v%0d_sel_held", v), sel_ok, 1);
      check($sformatf("v%0d_alu_a", v), alu_a, exp_a);
      check($sformatf("v%0d_alu_b", v), alu_b, exp_b);
      step();
      check($sformatf("v%0d_valid_drop", v), rsp_valid, 0);
      check($sformatf("v%0d_idle", v), busy, 0);
    end

    // Backpressure: capacity is DEPTH queued plus one in flight.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_op = 3'd4;
      req_a = 32'h01010101 * i; req_b = 32'h00FF00FF; req_tag = 4'(i);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_ready_low", req_ready, 0);
    held_data = rsp_data; held_tag = rsp_tag;
    check("bp_first_valid", rsp_valid, 1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!rsp_valid || rsp_data !== held_data || rsp_tag !== held_tag) stable = 1'b0;
    end
    check("bp_stall_stable", stable, 1);
    check("bp_ready_still_low", req_ready, 0);
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        if (n < 5) begin
          check($sformatf("bp_tag%0d", n), rsp_tag, 4'(n));
          check($sformatf("bp_data%0d", n), rsp_data, (32'h01010101 * n) ^ 32'h00FF00FF);
        end
        n++;
      end
      step();
    end
    check("bp_rsp_count", n, 5);
    check("bp_drained", busy, 0);

    // Reset during a divide with two requests queued behind it.
    t0 = cyc;
    req_valid = 1'b1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd5; req_tag = 4'd1;
    step();
    req_op = 3'd4; req_tag = 4'd2;
    step();
    req_op = 3'd2; req_tag = 4'd3;
    step();
    req_valid = 1'b0;
    check("flush_busy_before", busy, 1);
    check("flush_in_drive_sel", alu_sel, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_rsp_valid", rsp_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_req_ready", req_ready, 1);
    check("flush_alu", {alu_a, alu_b, 29'd0, alu_sel} != 64'd0, 0);
    check("flush_rsp", {rsp_data, rsp_tag, rsp_err} != 37'd0, 0);
    spurious = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rsp_valid) spurious++;
    end
    check("flush_no_rsp", spurious, 0);

    // Mixed ops with rsp_ready high only on odd cycles.
    m_op[0] = 3'd0; m_a[0] = 32'd10;   m_b[0] = 32'd20;   m_exp[0] = 32'd30;   m_lat[0] = 2;
    m_op[1] = 3'd1; m_a[1] = 32'd9;    m_b[1] = 32'd4;    m_exp[1] = 32'd4;    m_lat[1] = 1;
    m_op[2] = 3'd2; m_a[2] = 32'd3;    m_b[2] = 32'd5;    m_exp[2] = 32'd15;   m_lat[2] = 3;
    m_op[3] = 3'd4; m_a[3] = 32'hAA;   m_b[3] = 32'h55;   m_exp[3] = 32'hFF;   m_lat[3] = 1;
    t0 = cyc;
    begin
      int e, h;
      e = t0 + 2 + m_lat[0];
      for (int i = 0; i < 4; i++) begin
        exp_rise[i] = e;
        h = (e % 2 == 1) ? e : e + 1;
        if (i < 3) e = h + 2 + m_lat[i+1];
      end
    end
    idx = 0; seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      rsp_ready = (cyc % 2 == 1);
      if (cyc - t0 < 4) begin
        req_valid = 1'b1; req_op = m_op[cyc-t0]; req_a = m_a[cyc-t0];
        req_b = m_b[cyc-t0]; req_tag = 4'(cyc - t0 + 1);
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid && !seen && idx < 4) begin
        check($sformatf("mix%0d_rise", idx), cyc, exp_rise[idx]);
        check($sformatf("mix%0d_data", idx), rsp_data, m_exp[idx]);
        check($sformatf("mix%0d_tag", idx), rsp_tag, 4'(idx + 1));
        seen = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        idx++;
      end
      step();
    end
    req_valid = 1'b0;
    check("mix_count", idx, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
